// File: rtl/program_sequencer.sv
// program_sequencer: launches one or a chain of three programs into the core and times each run
module program_sequencer #(
  parameter int PCW     = 10,
  parameter int P1_ADDR = 0,
  parameter int P2_ADDR = 128,
  parameter int P3_ADDR = 256,
  parameter int TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           init,
  input  logic           chain,
  input  logic [1:0]     prog_sel,
  input  logic           cpu_halt,
  output logic           cpu_start,
  output logic [PCW-1:0] cpu_pc,
  output logic           cpu_hold,
  output logic [1:0]     prog_id,
  output logic           done,
  output logic           timeout,
  output logic [15:0]    cycle_ct
);
  typedef enum logic [2:0] {IDLE, ARMED, LAUNCH, RUN, NEXT, FIN} state_t;
  state_t      state;
  logic        chain_r;
  logic [1:0]  idx;
  logic [15:0] cnt;
  logic [1:0]  first_idx;
  logic [1:0]  next_idx;
  logic [15:0] cnt_sat;
  logic        expired;
  function automatic logic [PCW-1:0] addr(input logic [1:0] i);
    return i == 2'd3 ? PCW'(P3_ADDR) : i == 2'd2 ? PCW'(P2_ADDR) : PCW'(P1_ADDR);
  endfunction
  assign first_idx = (chain || prog_sel == 2'd0) ? 2'd1 : prog_sel;
  assign next_idx  = idx + 2'd1;
  assign cnt_sat   = &cnt ? cnt : cnt + 16'd1;
  assign expired   = ({1'b0, cnt} + 17'd1) >= 17'(TIMEOUT);
  // launch/run/abort sequencing with all outputs registered alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      chain_r   <= 1'b0;
      idx       <= 2'd0;
      cnt       <= 16'd0;
      cpu_start <= 1'b0;
      cpu_pc    <= '0;
      cpu_hold  <= 1'b1;
      prog_id   <= 2'd0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_ct  <= 16'd0;
    end else if (init && (state == LAUNCH || state == RUN || state == NEXT)) begin
      state     <= ARMED;
      cpu_start <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (init) state <= ARMED;
        ARMED: if (!init) begin
          state     <= LAUNCH;
          chain_r   <= chain;
          idx       <= first_idx;
          timeout   <= 1'b0;
          cnt       <= 16'd0;
          cpu_start <= 1'b1;
          cpu_hold  <= 1'b0;
          cpu_pc    <= addr(first_idx);
          prog_id   <= first_idx;
        end
        LAUNCH: begin
          state     <= RUN;
          cpu_start <= 1'b0;
        end
        RUN: begin
          cnt <= cnt_sat;
          if (cpu_halt) begin
            state    <= NEXT;
            cpu_hold <= 1'b1;
            cycle_ct <= cnt_sat;
          end else if (expired) begin
            state    <= FIN;
            cpu_hold <= 1'b1;
            timeout  <= 1'b1;
            done     <= 1'b1;
            cycle_ct <= cnt_sat;
          end
        end
        NEXT: if (chain_r && idx < 2'd3) begin
          state     <= LAUNCH;
          idx       <= next_idx;
          cnt       <= 16'd0;
          cpu_start <= 1'b1;
          cpu_hold  <= 1'b0;
          cpu_pc    <= addr(next_idx);
          prog_id   <= next_idx;
        end else begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN: if (init) begin
          state <= ARMED;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and randomized launch scenarios checked against a run-level model
module tb_program_sequencer;
  logic       clk = 1'b0, reset = 1'b1, init = 1'b0, chain = 1'b0, cpu_halt = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic       cpu_start, cpu_hold, done, timeout;
  logic [9:0] cpu_pc;
  logic [1:0] prog_id;
  logic [15:0] cycle_ct;
  int n_chk = 0, n_fail = 0;
  logic [9:0] launches[$];

  always #5 clk = ~clk;

  program_sequencer #(.TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .init(init), .chain(chain), .prog_sel(prog_sel),
    .cpu_halt(cpu_halt), .cpu_start(cpu_start), .cpu_pc(cpu_pc), .cpu_hold(cpu_hold),
    .prog_id(prog_id), .done(done), .timeout(timeout), .cycle_ct(cycle_ct)
  );

  // every start pulse records the address the core was given
  always @(posedge clk) if (cpu_start === 1'b1) launches.push_back(cpu_pc);

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // programs sit 128 words apart starting at 0
  function automatic logic [9:0] model_pc(input int id);
    return 10'((id - 1) * 128);
  endfunction

  task automatic launch_req(input logic ch, input logic [1:0] sel, input int hc);
    chain = ch;
    prog_sel = sel;
    init = 1'b1;
    step(hc);
    chk("armed_done_low", done, 0);
    init = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (cpu_start !== 1'b1 && k < 40) begin step(); k++; end
    chk(tag, cpu_start, 1);
  endtask

  // core runs r cycles with the halt arriving in the last of them
  task automatic halt_after(input int r);
    step(r);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
  endtask

  initial begin
    int dl[3] = '{6, 8, 10};
    reset = 1'b0;
    #1;
    chk("rst_hold", cpu_hold, 1);
    chk("rst_start", cpu_start, 0);
    chk("rst_pc", cpu_pc, 0);
    step(2);
    chk("rst_prog_id", prog_id, 0);
    chk("rst_done_to_ct", {done, timeout, cycle_ct}, 0);
    reset = 1'b1;
    step();
    cpu_halt = 1'b1; step(); cpu_halt = 1'b0; step();
    chk("idle_halt_hold", cpu_hold, 1);
    chk("idle_halt_nolaunch", launches.size(), 0);

    launches.delete();
    launch_req(1'b0, 2'd2, 2);
    step();
    chk("single_latency", cpu_start, 1);
    chain = 1'b1; prog_sel = 2'd3;
    chk("single_pc", cpu_pc, 128);
    chk("single_id", prog_id, 2);
    step();
    chk("run_hold", cpu_hold, 0);
    halt_after(10);
    chk("single_done_h1", done, 0);
    chk("single_ct", cycle_ct, 11);
    step();
    chk("single_done_h2", done, 1);
    chk("single_fin_hold", cpu_hold, 1);
    chk("single_count", launches.size(), 1);
    cpu_halt = 1'b1; step(); cpu_halt = 1'b0; step();
    chk("fin_halt_done", done, 1);
    chk("fin_halt_nolaunch", launches.size(), 1);

    launches.delete();
    launch_req(1'b1, 2'd0, 1);
    for (int i = 0; i < 3; i++) begin
      wait_start("chain_start");
      chk("chain_pc", cpu_pc, model_pc(i + 1));
      halt_after(dl[i]);
      chk("chain_next_nostart", cpu_start, 0);
      step();
      chk(i < 2 ? "chain_relaunch" : "chain_done", i < 2 ? cpu_start : done, 1);
    end
    chk("chain_ct", cycle_ct, 10);
    chk("chain_id", prog_id, 3);
    chk("chain_count", launches.size(), 3);
    foreach (launches[j]) chk("chain_order", launches[j], model_pc(j + 1));

    launch_req(1'b0, 2'd1, 1);
    wait_start("to_start");
    step(20);
    chk("to_before_done", {done, timeout}, 0);
    step();
    chk("to_flag", timeout, 1);
    chk("to_done", done, 1);
    chk("to_hold", cpu_hold, 1);

    launches.delete();
    launch_req(1'b1, 2'd3, 1);
    wait_start("abort_p1");
    chk("to_cleared", timeout, 0);
    halt_after(3);
    wait_start("abort_p2");
    step(2);
    init = 1'b1;
    step();
    chk("abort_hold", cpu_hold, 1);
    chk("abort_ct_kept", cycle_ct, 3);
    step(3);
    chk("abort_no_done", done, 0);
    chk("abort_no_p3", launches.size(), 2);
    init = 1'b0;
    wait_start("abort_restart");
    chk("abort_restart_pc", cpu_pc, 0);
    step(3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_outs", {cpu_start, cpu_hold, cpu_pc, prog_id, done, timeout, cycle_ct}, 32'h1_0000 >> 0 == 0 ? 0 : {1'b0, 1'b1, 10'd0, 2'd0, 1'b0, 1'b0, 16'd0});
    step();
    reset = 1'b1;
    step(2);
    chk("post_rst_idle", {cpu_start, cpu_hold, done}, 3'b010);

    launches.delete();
    launch_req(1'b0, 2'd0, 1);
    wait_start("sel0_start");
    chk("sel0_pc", cpu_pc, 0);
    chk("sel0_id", prog_id, 1);
    halt_after(1);
    step();
    chk("min_run_ct", cycle_ct, 1);
    chk("sel0_done", done, 1);

    for (int it = 0; it < 8; it++) begin
      logic ch;
      logic [1:0] sel;
      int exp_ids[$];
      ch = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      exp_ids.delete();
      if (ch) exp_ids = '{1, 2, 3};
      else exp_ids.push_back(sel == 2'd0 ? 1 : int'(sel));
      launches.delete();
      launch_req(ch, sel, $urandom_range(1, 3));
      foreach (exp_ids[j]) begin
        int r;
        wait_start("rnd_start");
        if (j == 0) begin chain = ~ch; prog_sel = 2'($urandom_range(0, 3)); end
        chk("rnd_pc", cpu_pc, model_pc(exp_ids[j]));
        chk("rnd_id", prog_id, exp_ids[j]);
        r = $urandom_range(1, 15);
        halt_after(r);
        chk("rnd_ct", cycle_ct, r);
        step();
      end
      chk("rnd_done", done, 1);
      chk("rnd_count", launches.size(), exp_ids.size());
      foreach (launches[j]) chk("rnd_order", launches[j], model_pc(exp_ids[j]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
